// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the 4-digit multiplexed 7-segment scan controller.
package display_pkg;

    localparam int          SEG_W    = 7;
    localparam int          N_DIGITS = 4;
    localparam logic [3:0]  CELL_OFF = 4'b1111;

    typedef logic [SEG_W-1:0] seg_t;

    // Phase of the current digit slot.
    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_LIT   = 2'd1,
        PH_DARK  = 2'd2
    } phase_t;

    // Active-low one-cold cell select for digit idx.
    function automatic logic [N_DIGITS-1:0] cell_sel(input logic [1:0] idx);
        cell_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Shadow-bank write port: valid/ready write channel plus the commit pulse.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    seg_t       wr_data;
    logic       commit;

    modport master (output wr_valid, output wr_addr, output wr_data, output commit, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, input commit, output wr_ready);

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timer: counts cycles within a digit slot, steps digits 3->2->1->0 and
// tracks the BLANK/LIT/DARK phase using the brightness captured at slot start.
module scan_timer
    import display_pkg::*;
#(
    parameter int CLK_DIV      = 48000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] brightness,
    output logic [1:0] digit,
    output phase_t     phase,
    output logic       slot_start,
    output logic       frame_boundary
);

    localparam int                CNT_W   = $clog2(CLK_DIV);
    localparam int                SUB     = (CLK_DIV - BLANK_CYCLES) / 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LIT = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       digit_r;
    logic [1:0]       digit_nxt_s;
    logic [3:0]       b_r;
    phase_t           phase_r;
    phase_t           phase_nxt_s;
    logic [31:0]      p_nxt_s;
    logic [31:0]      lim_s;

    // Next counter/digit value; digit wraps 0 -> 3 by 2-bit underflow.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        digit_nxt_s = digit_r;
        if (cnt_r == CNT_MAX) begin
            cnt_nxt_s   = '0;
            digit_nxt_s = digit_r - 2'd1;
        end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            digit_nxt_s = digit_r;
        end
    end

    assign p_nxt_s = 32'(cnt_nxt_s) - 32'(BLANK_CYCLES);
    assign lim_s   = 32'(SUB) * (32'(b_r) + 32'd1);

    // Phase next-state: blank window, then lit for SUB*(b+1) cycles, then dark.
    always_comb begin
        phase_nxt_s = phase_r;
        case (phase_r)
            PH_BLANK: begin
                if (cnt_nxt_s == CNT_LIT) phase_nxt_s = PH_LIT;
                else                      phase_nxt_s = PH_BLANK;
            end
            PH_LIT: begin
                if (cnt_nxt_s == '0)        phase_nxt_s = PH_BLANK;
                else if (p_nxt_s >= lim_s)  phase_nxt_s = PH_DARK;
                else                        phase_nxt_s = PH_LIT;
            end
            PH_DARK: begin
                if (cnt_nxt_s == '0) phase_nxt_s = PH_BLANK;
                else                 phase_nxt_s = PH_DARK;
            end
            default: phase_nxt_s = PH_BLANK;
        endcase
    end

    // Timer state registers; brightness is frozen for the slot at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            digit_r <= 2'd3;
            phase_r <= PH_BLANK;
            b_r     <= 4'd0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            digit_r <= digit_nxt_s;
            phase_r <= phase_nxt_s;
            if (cnt_r == '0) b_r <= brightness;
            else             b_r <= b_r;
        end
    end

    assign digit          = digit_r;
    assign phase          = phase_r;
    assign slot_start     = (cnt_r == '0);
    assign frame_boundary = (digit_r == 2'd0) && (cnt_r == CNT_MAX);

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan controller top: double-buffered digit bank with commit-at-frame,
// per-digit enables and registered segment/cell pins.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int   CLK_DIV      = 48000,
    parameter int   BLANK_CYCLES = 16,
    parameter seg_t SEG_OFF      = 7'h7F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scan_ctrl_if.slave   wr,
    input  logic [3:0]           brightness,
    input  logic [3:0]           digit_en,
    output seg_t                 linker_segment,
    output logic [3:0]           current_cell,
    output logic                 frame_done
);

    seg_t        shadow_r [N_DIGITS];
    seg_t        active_r [N_DIGITS];
    logic        pending_r;
    logic [3:0]  en_r;
    seg_t        seg_r;
    logic [3:0]  cell_r;
    logic        frame_done_r;

    logic [1:0]  digit_s;
    phase_t      phase_s;
    logic        slot_start_s;
    logic        boundary_s;
    logic        wr_accept_s;
    seg_t        seg_nxt_s;
    logic [3:0]  cell_nxt_s;

    scan_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .brightness     (brightness),
        .digit          (digit_s),
        .phase          (phase_s),
        .slot_start     (slot_start_s),
        .frame_boundary (boundary_s)
    );

    assign wr_accept_s = wr.wr_valid & ~pending_r;
    assign wr.wr_ready = ~pending_r;

    // Shadow bank writes and publish of the whole shadow bank at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            if (wr_accept_s) shadow_r[wr.wr_addr] <= wr.wr_data;
            else             shadow_r <= shadow_r;
            if (boundary_s && pending_r) active_r <= shadow_r;
            else                         active_r <= active_r;
        end
    end

    // Commit-pending flag: set by commit, cleared when the bank is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (boundary_s && pending_r) begin
            pending_r <= 1'b0;
        end else if (wr.commit && !pending_r) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Digit enables are frozen for the slot at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            en_r <= 4'b0000;
        else if (slot_start_s) en_r <= digit_en;
        else                   en_r <= en_r;
    end

    // Pin values for the current timer state; disabled digits stay dark.
    always_comb begin
        cell_nxt_s = CELL_OFF;
        seg_nxt_s  = SEG_OFF;
        if ((phase_s == PH_LIT) && en_r[digit_s]) begin
            cell_nxt_s = cell_sel(digit_s);
            seg_nxt_s  = active_r[digit_s];
        end else begin
            cell_nxt_s = CELL_OFF;
            seg_nxt_s  = SEG_OFF;
        end
    end

    // Output registers: pins lag the timer state by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r        <= SEG_OFF;
            cell_r       <= CELL_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            cell_r       <= cell_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign linker_segment = seg_r;
    assign current_cell   = cell_r;
    assign frame_done     = frame_done_r;

endmodule
